fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset; synchronous and active-high.
REQ-004 SHALL have port enq_valid, input, 1 bit: fetch presents an instruction (instruction-memory hit and no fetch stall).
REQ-005 SHALL have port enq_pc, input, 32 bits (word_t): PC of the presented instruction.
REQ-006 SHALL have port enq_instr, input, 32 bits (word_t): instruction word read from instruction memory.
REQ-007 SHALL have port enq_pred_pc, input, 32 bits (word_t): predicted next PC, used later for branch resolution.
REQ-008 SHALL have port flush, input, 1 bit: misprediction; discard all queued entries.
REQ-009 SHALL have port deq_ready, input, 1 bit: dispatch accepts the head entry this cycle.
REQ-010 SHALL have port deq_valid, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port deq_pc, output, 32 bits: PC of the head entry.
REQ-012 SHALL have port deq_instr, output, 32 bits: instruction of the head entry.
REQ-013 SHALL have port deq_pred_pc, output, 32 bits: predicted next PC of the head entry.
REQ-014 SHALL have port dispatch_free, output, 1 bit: the queue can accept an enqueue this cycle; fetch uses it to hold its PC.
REQ-015 SHALL have port count, output, $clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-016 SHALL implement a circular buffer with head pointer, tail pointer and occupancy counter; pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
REQ-017 SHALL drive dispatch_free = (count != DEPTH) combinationally from registered state only, with no path from enq_valid or deq_ready.
REQ-018 SHALL enqueue (write {enq_pc, enq_instr, enq_pred_pc} at tail, tail+1, count+1) when enq_valid && dispatch_free && !flush.
REQ-019 SHALL ignore enq_valid when full, even if a dequeue occurs in the same cycle; no bypass and no overwrite.
REQ-020 SHALL drive deq_valid = (count != 0); deq_* outputs SHALL come directly from the head entry, giving zero-cycle read latency.
REQ-021 SHALL dequeue (head+1, count-1) when deq_valid && deq_ready && !flush.
REQ-022 SHALL, on simultaneous enqueue and dequeue with 0 < count < DEPTH, advance both pointers and leave count unchanged.
REQ-023 SHALL ignore deq_ready when empty.
REQ-024 SHALL keep an entry enqueued while empty off deq_valid until the next cycle; minimum latency from enqueue to visibility is 1 cycle, with no flow-through.
REQ-025 SHALL give flush highest priority: on a flush cycle, head=0, tail=0, count=0 next cycle, and any concurrent enqueue or dequeue is dropped.
REQ-026 SHALL never read or corrupt entry storage based on unoccupied slots; data in empty slots is don't-care, but deq_* SHALL be stable while deq_valid=1 && deq_ready=0.

Reset
REQ-027 SHALL, with RST high at a rising CLK edge, set head=0, tail=0, count=0; deq_valid=0 and dispatch_free=1 from the next cycle.
REQ-028 SHALL NOT require entry storage to be reset.
REQ-029 SHALL give RST priority over flush, enqueue and dequeue; RST asserted mid-stream discards all contents.

Structure
REQ-030 SHALL define fetch_entry_t (packed struct: pc, instr, pred_pc, each word_t) in isa_pkg, alongside word_t.
REQ-031 SHALL keep DEPTH as a module parameter, not a package constant.
REQ-032 SHALL be a single module with no sub-modules; storage is a fetch_entry_t array indexed by the pointers.

Verification
REQ-033 SHALL cover fill: reset, then 4 enqueues with pc 0x00,0x04,0x08,0x0C and deq_ready=0 -> count=4, dispatch_free=0; a 5th enq_valid with pc 0x10 is dropped.
REQ-034 SHALL cover drain order: from the full state, deq_ready=1 for 4 cycles -> deq_pc sequence 0x00,0x04,0x08,0x0C, then deq_valid=0 and count=0.
REQ-035 SHALL cover simultaneous operation: at count=2, enq_valid=1 and deq_ready=1 for 10 cycles -> count stays 2, pointers wrap, order preserved, no data loss.
REQ-036 SHALL cover flush: at count=3 with enq_valid=1 and deq_ready=1, assert flush -> next cycle count=0, deq_valid=0, dispatch_free=1, flushed-cycle pc never appears.
REQ-037 SHALL cover reset mid-stream: at count=3, RST=1 together with enq_valid=1 -> next cycle count=0; then a single enqueue of pc 0x40 -> deq_pc=0x40 exactly one cycle later.
REQ-038 SHALL cover stall hold: at count=1 with deq_ready=0 for 5 cycles -> deq_pc, deq_instr and deq_pred_pc remain constant.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA types for the fetch side of the pipeline.
// word_t is the 32-bit machine word; fetch_entry_t is one queued fetch.
package isa_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    word_t pred_pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-dispatch instruction queue (circular buffer).
// Ports: CLK, RST (sync, active-high); enq_valid/enq_pc/enq_instr/
//   enq_pred_pc from fetch; flush on mispredict; deq_ready from
//   dispatch; deq_valid/deq_pc/deq_instr/deq_pred_pc head entry;
//   dispatch_free (not full, registered-only); count (occupancy).
module fetch_queue
  import isa_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enq_valid,
  input  word_t                      enq_pc,
  input  word_t                      enq_instr,
  input  word_t                      enq_pred_pc,
  input  logic                       flush,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output word_t                      deq_pc,
  output word_t                      deq_instr,
  output word_t                      deq_pred_pc,
  output logic                       dispatch_free,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  fetch_entry_t mem [DEPTH];
  fetch_entry_t hd;

  logic full;
  logic do_enq;
  logic do_deq;

  // Status depends on registered occupancy only, so fetch never sees
  // a combinational path from its own enq_valid or from deq_ready.
  assign full          = (cnt == CW'(DEPTH));
  assign dispatch_free = !full;
  assign deq_valid     = (cnt != '0);
  assign count         = cnt;

  // Full blocks enqueue even when a dequeue happens in the same cycle.
  assign do_enq = enq_valid && !full && !flush;
  assign do_deq = deq_valid && deq_ready && !flush;

  assign hd          = mem[head];
  assign deq_pc      = hd.pc;
  assign deq_instr   = hd.instr;
  assign deq_pred_pc = hd.pred_pc;

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_enq) tail <= tail + PW'(1);
      if (do_deq) head <= head + PW'(1);
      unique case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; only occupied slots are ever presented.
  always_ff @(posedge CLK) begin
    if (!RST && do_enq) begin
      mem[tail] <= '{pc: enq_pc, instr: enq_instr, pred_pc: enq_pred_pc};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: FIFO reference model plus
// directed scenarios with literal expectations and random traffic.
module tb_fetch_queue;
  import isa_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        enq_valid = 1'b0;
  word_t       enq_pc = '0;
  word_t       enq_instr = '0;
  word_t       enq_pred_pc = '0;
  logic        flush = 1'b0;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  word_t       deq_pc;
  word_t       deq_instr;
  word_t       deq_pred_pc;
  logic        dispatch_free;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .enq_valid    (enq_valid),
    .enq_pc       (enq_pc),
    .enq_instr    (enq_instr),
    .enq_pred_pc  (enq_pred_pc),
    .flush        (flush),
    .deq_ready    (deq_ready),
    .deq_valid    (deq_valid),
    .deq_pc       (deq_pc),
    .deq_instr    (deq_instr),
    .deq_pred_pc  (deq_pred_pc),
    .dispatch_free(dispatch_free),
    .count        (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of entries.
  fetch_entry_t q[$];
  bit           mvalid = 0;

  always @(posedge CLK) begin
    if (RST) begin
      q.delete();
      mvalid = 1;
    end else if (mvalid) begin
      if (flush) begin
        q.delete();
      end else begin
        bit push;
        bit pop;
        push = enq_valid && (q.size() < DEPTH);
        pop  = deq_ready && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (push)
          q.push_back('{pc: enq_pc, instr: enq_instr,
                        pred_pc: enq_pred_pc});
      end
    end
  end

  always @(negedge CLK) begin
    if (mvalid) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_deq_valid", 32'(deq_valid), 32'(q.size() != 0));
      chk("m_free", 32'(dispatch_free), 32'(q.size() != DEPTH));
      if (q.size() != 0) begin
        chk("m_deq_pc", deq_pc, q[0].pc);
        chk("m_deq_instr", deq_instr, q[0].instr);
        chk("m_deq_pred", deq_pred_pc, q[0].pred_pc);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic word_t ins_of(input word_t pc);
    return pc ^ 32'hdead_beef;
  endfunction

  task automatic set_enq(input logic v, input word_t pc);
    enq_valid   = v;
    enq_pc      = pc;
    enq_instr   = ins_of(pc);
    enq_pred_pc = pc + 32'd4;
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(deq_valid), 32'd0);
    chk("rst_free", 32'(dispatch_free), 32'd1);

    // Fill, then a dropped 5th enqueue
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, word_t'(i * 4));
      step();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_free", 32'(dispatch_free), 32'd0);
    set_enq(1'b1, 32'h10);
    step();
    set_enq(1'b0, 32'h0);
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_head", deq_pc, 32'h0);

    // Drain order
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", deq_pc, word_t'(i * 4));
      step();
    end
    chk("drain_valid", 32'(deq_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    deq_ready = 1'b0;

    // Simultaneous enqueue/dequeue at count=2
    set_enq(1'b1, 32'h100);
    step();
    set_enq(1'b1, 32'h104);
    step();
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_enq(1'b1, 32'h108 + word_t'(i * 4));
      chk("sim_pc", deq_pc, 32'h100 + word_t'(i * 4));
      step();
      chk("sim_count", 32'(count), 32'd2);
    end
    chk("sim_head", deq_pc, 32'h128);
    deq_ready = 1'b0;

    // Flush at count=3 with concurrent enq/deq
    set_enq(1'b1, 32'h200);
    step();
    chk("pre_flush_count", 32'(count), 32'd3);
    set_enq(1'b1, 32'h300);
    deq_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    deq_ready = 1'b0;
    set_enq(1'b0, 32'h0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(deq_valid), 32'd0);
    chk("flush_free", 32'(dispatch_free), 32'd1);
    step();
    chk("flush_stays", 32'(deq_valid), 32'd0);

    // Reset mid-stream at count=3
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h20 + word_t'(i * 4));
      step();
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    RST = 1'b1;
    set_enq(1'b1, 32'h2c);
    step();
    RST = 1'b0;
    set_enq(1'b0, 32'h0);
    chk("mrst_count", 32'(count), 32'd0);
    set_enq(1'b1, 32'h40);
    chk("enq_not_visible", 32'(deq_valid), 32'd0);
    step();
    set_enq(1'b0, 32'h0);
    chk("post_rst_valid", 32'(deq_valid), 32'd1);
    chk("post_rst_pc", deq_pc, 32'h40);

    // Stall hold at count=1
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_pc", deq_pc, 32'h40);
      chk("hold_instr", deq_instr, ins_of(32'h40));
      chk("hold_pred", deq_pred_pc, 32'h44);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      enq_valid   = ($urandom_range(0, 3) != 0);
      enq_pc      = $urandom;
      enq_instr   = $urandom;
      enq_pred_pc = $urandom;
      deq_ready   = ($urandom_range(0, 2) != 0);
      if (i % 500 < 100) deq_ready = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 31) == 0);
      RST         = ($urandom_range(0, 127) == 0);
      step();
    end
    RST = 1'b0;
    flush = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
